// File: rtl/cdp1802_ioports.sv
// cdp1802_ioports: bridges the core's N-line I/O strobes to up to seven
// device channels. Each channel has a TX FIFO filled by OUT and an RX FIFO
// drained by INP. The device side of each FIFO is a valid/ready stream.
// FIFO status is reported to the core on the EF sense lines.
module cdp1802_ioports #(
  parameter int NCH     = 3,
  parameter int DEPTH   = 4,
  parameter int EF_MODE = 0
) (
  input  logic               clock,
  input  logic               resetq,
  input  logic [2:0]         n,
  input  logic               inp,
  input  logic [7:0]         bus_out,
  output logic [7:0]         bus_in,
  output logic [3:0]         EF,
  output logic [NCH-1:0]     tx_valid,
  output logic [8*NCH-1:0]   tx_data,
  input  logic [NCH-1:0]     tx_ready,
  input  logic [NCH-1:0]     rx_valid,
  input  logic [8*NCH-1:0]   rx_data,
  output logic [NCH-1:0]     rx_ready,
  input  logic               err_clr,
  output logic [NCH-1:0]     ovf,
  output logic [NCH-1:0]     unf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    tx_mem [NCH][DEPTH];
  logic [7:0]    rx_mem [NCH][DEPTH];
  logic [AW-1:0] tx_rp [NCH];
  logic [AW-1:0] tx_wp [NCH];
  logic [AW:0]   tx_cnt [NCH];
  logic [AW-1:0] rx_rp [NCH];
  logic [AW-1:0] rx_wp [NCH];
  logic [AW:0]   rx_cnt [NCH];

  logic [NCH-1:0] out_stb, in_stb;
  logic [NCH-1:0] tx_full, rx_nempty;
  logic [NCH-1:0] tx_push, tx_pop, rx_push, rx_pop;
  logic [NCH-1:0] ovf_set, unf_set;

  // Decode strobes and derive push/pop/status from the pre-edge counts.
  // Channels with n above NCH never match, so those strobes fall through.
  always_comb begin
    out_stb   = '0;
    in_stb    = '0;
    tx_full   = '0;
    rx_nempty = '0;
    tx_valid  = '0;
    rx_ready  = '0;
    tx_push   = '0;
    tx_pop    = '0;
    rx_push   = '0;
    rx_pop    = '0;
    ovf_set   = '0;
    unf_set   = '0;
    tx_data   = '0;
    bus_in    = 8'h00;
    for (int c = 0; c < NCH; c++) begin
      out_stb[c]   = (n == 3'(c + 1)) && !inp;
      in_stb[c]    = (n == 3'(c + 1)) && inp;
      tx_full[c]   = (tx_cnt[c] == FULL_CNT);
      tx_valid[c]  = (tx_cnt[c] != '0);
      rx_nempty[c] = (rx_cnt[c] != '0);
      rx_ready[c]  = (rx_cnt[c] != FULL_CNT);
      tx_push[c]   = out_stb[c] && !tx_full[c];
      tx_pop[c]    = tx_valid[c] && tx_ready[c];
      rx_push[c]   = rx_valid[c] && rx_ready[c];
      rx_pop[c]    = in_stb[c] && rx_nempty[c];
      ovf_set[c]   = out_stb[c] && tx_full[c];
      unf_set[c]   = in_stb[c] && !rx_nempty[c];
      tx_data[8*c +: 8] = tx_mem[c][tx_rp[c]];
      if (rx_pop[c])
        bus_in = rx_mem[c][rx_rp[c]];
    end
  end

  // EF lines beyond the configured channel count are tied low.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ef
      if (gi < NCH) begin : g_used
        if (EF_MODE == 1) begin : g_txfull
          assign EF[gi] = tx_full[gi];
        end else begin : g_rxne
          assign EF[gi] = rx_nempty[gi];
        end
      end else begin : g_unused
        assign EF[gi] = 1'b0;
      end
    end
  endgenerate

  // FIFO data storage; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    for (int c = 0; c < NCH; c++) begin
      if (tx_push[c])
        tx_mem[c][tx_wp[c]] <= bus_out;
      if (rx_push[c])
        rx_mem[c][rx_wp[c]] <= rx_data[8*c +: 8];
    end
  end

  // Pointer, count and sticky error flag state; a set beats err_clr.
  always_ff @(posedge clock or negedge resetq) begin
    if (!resetq) begin
      for (int c = 0; c < NCH; c++) begin
        tx_rp[c]  <= '0;
        tx_wp[c]  <= '0;
        tx_cnt[c] <= '0;
        rx_rp[c]  <= '0;
        rx_wp[c]  <= '0;
        rx_cnt[c] <= '0;
      end
      ovf <= '0;
      unf <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (tx_push[c]) tx_wp[c] <= tx_wp[c] + 1'b1;
        if (tx_pop[c])  tx_rp[c] <= tx_rp[c] + 1'b1;
        case ({tx_push[c], tx_pop[c]})
          2'b10:   tx_cnt[c] <= tx_cnt[c] + 1'b1;
          2'b01:   tx_cnt[c] <= tx_cnt[c] - 1'b1;
          default: tx_cnt[c] <= tx_cnt[c];
        endcase
        if (rx_push[c]) rx_wp[c] <= rx_wp[c] + 1'b1;
        if (rx_pop[c])  rx_rp[c] <= rx_rp[c] + 1'b1;
        case ({rx_push[c], rx_pop[c]})
          2'b10:   rx_cnt[c] <= rx_cnt[c] + 1'b1;
          2'b01:   rx_cnt[c] <= rx_cnt[c] - 1'b1;
          default: rx_cnt[c] <= rx_cnt[c];
        endcase
      end
      ovf <= (ovf & ~{NCH{err_clr}}) | ovf_set;
      unf <= (unf & ~{NCH{err_clr}}) | unf_set;
    end
  end

endmodule

// File: tb/tb_cdp1802_ioports.sv
// tb_cdp1802_ioports: directed checks of the I/O port block. Two instances
// share every input; dut uses EF_MODE 0 (RX non-empty) and dut1 EF_MODE 1
// (TX full), so both flag meanings are observed on the same traffic.
module tb_cdp1802_ioports;

  logic        clock = 1'b0;
  logic        resetq;
  logic [2:0]  n;
  logic        inp;
  logic [7:0]  bus_out;
  logic [2:0]  tx_ready;
  logic [2:0]  rx_valid;
  logic [23:0] rx_data;
  logic        err_clr;

  logic [7:0]  bus_in,   bus_in1;
  logic [3:0]  EF,       EF1;
  logic [2:0]  tx_valid, tx_valid1;
  logic [23:0] tx_data,  tx_data1;
  logic [2:0]  rx_ready, rx_ready1;
  logic [2:0]  ovf,      ovf1;
  logic [2:0]  unf,      unf1;

  int tests    = 0;
  int failures = 0;

  cdp1802_ioports #(.NCH(3), .DEPTH(4), .EF_MODE(0)) dut (
    .clock(clock), .resetq(resetq), .n(n), .inp(inp), .bus_out(bus_out),
    .bus_in(bus_in), .EF(EF), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .err_clr(err_clr), .ovf(ovf), .unf(unf)
  );

  cdp1802_ioports #(.NCH(3), .DEPTH(4), .EF_MODE(1)) dut1 (
    .clock(clock), .resetq(resetq), .n(n), .inp(inp), .bus_out(bus_out),
    .bus_in(bus_in1), .EF(EF1), .tx_valid(tx_valid1), .tx_data(tx_data1),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready1), .err_clr(err_clr), .ovf(ovf1), .unf(unf1)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive the core-side strobe and let combinational outputs settle.
  task automatic applyStimulus(input logic [2:0] nv, input logic iv,
                               input logic [7:0] dv);
    n       = nv;
    inp     = iv;
    bus_out = dv;
    #1;
  endtask

  // One comparison: counts it, reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Device pushes one byte into RX channel index ch (0-based).
  task automatic pushRx(input int ch, input logic [7:0] d);
    rx_valid[ch]       = 1'b1;
    rx_data[8*ch +: 8] = d;
    tick();
    rx_valid[ch] = 1'b0;
  endtask

  // Pulse err_clr for one cycle.
  task automatic clearErrors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // Directed sequence covering reset, both FIFO directions, flags and EF.
  initial begin
    logic [7:0] bytes [5];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    bytes[3] = 8'h44; bytes[4] = 8'h55;

    resetq = 1'b0; n = 3'd0; inp = 1'b0; bus_out = 8'h00;
    tx_ready = 3'b000; rx_valid = 3'b000; rx_data = 24'h0; err_clr = 1'b0;
    #2;
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'h7);
    checkOutput("rst_ef",       32'(EF),       32'h0);
    checkOutput("rst_ef_mode1", 32'(EF1),      32'h0);
    checkOutput("rst_bus_in",   32'(bus_in),   32'h0);
    tick();
    resetq = 1'b1;
    tick();

    // OUT to channel 2 with the device stalled; fifth byte overflows.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'd2, 1'b0, bytes[i]);
      tick();
      if (i == 0) begin
        checkOutput("out_first_valid", 32'(tx_valid), 32'h2);
        checkOutput("out_first_data",  32'(tx_data[15:8]), 32'h11);
      end
    end
    applyStimulus(3'd0, 1'b0, 8'h00);
    checkOutput("out_ovf",        32'(ovf),      32'h2);
    checkOutput("out_full_valid", 32'(tx_valid), 32'h2);
    checkOutput("out_ef_mode1",   32'(EF1),      32'h2);
    checkOutput("out_ef_mode0",   32'(EF),       32'h0);

    // Device drains channel 2 in order.
    tx_ready = 3'b010;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("drain_valid", 32'(tx_valid[1]), 32'h1);
      checkOutput("drain_data",  32'(tx_data[15:8]), 32'(bytes[i]));
      tick();
    end
    checkOutput("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 3'b000;
    clearErrors();
    checkOutput("ovf_cleared", 32'(ovf), 32'h0);

    // INP on channel 1: one byte then an underflow.
    pushRx(0, 8'hA5);
    checkOutput("inp_ef0", 32'(EF), 32'h1);
    applyStimulus(3'd1, 1'b1, 8'h00);
    checkOutput("inp_data", 32'(bus_in), 32'hA5);
    tick();
    #1;
    checkOutput("inp_empty_data", 32'(bus_in), 32'h00);
    tick();
    applyStimulus(3'd0, 1'b0, 8'h00);
    checkOutput("inp_unf", 32'(unf), 32'h1);
    checkOutput("inp_ef_after", 32'(EF), 32'h0);
    clearErrors();
    checkOutput("unf_cleared", 32'(unf), 32'h0);

    // Underflow coinciding with err_clr: the set wins.
    applyStimulus(3'd1, 1'b1, 8'h00);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    applyStimulus(3'd0, 1'b0, 8'h00);
    checkOutput("unf_set_wins", 32'(unf), 32'h1);
    clearErrors();

    // Pop refused on empty RX while a push lands in the same cycle.
    rx_valid[0] = 1'b1;
    rx_data[7:0] = 8'h77;
    applyStimulus(3'd1, 1'b1, 8'h00);
    checkOutput("emptypop_bus", 32'(bus_in), 32'h00);
    tick();
    rx_valid[0] = 1'b0;
    applyStimulus(3'd1, 1'b1, 8'h00);
    checkOutput("emptypop_unf", 32'(unf), 32'h1);
    checkOutput("emptypop_pushed", 32'(bus_in), 32'h77);
    tick();
    applyStimulus(3'd0, 1'b0, 8'h00);
    clearErrors();

    // EF mode 0 on channel 3.
    pushRx(2, 8'h3C);
    checkOutput("ef2_raise", 32'(EF), 32'h4);
    applyStimulus(3'd3, 1'b1, 8'h00);
    checkOutput("ef2_data", 32'(bus_in), 32'h3C);
    tick();
    applyStimulus(3'd0, 1'b0, 8'h00);
    checkOutput("ef2_fall", 32'(EF), 32'h0);

    // EF mode 1: fill TX of channel 1.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'd1, 1'b0, 8'(8'h81 + i));
      tick();
      if (i == 2)
        checkOutput("ef_mode1_three", 32'(EF1), 32'h0);
    end
    applyStimulus(3'd0, 1'b0, 8'h00);
    checkOutput("ef_mode1_full", 32'(EF1), 32'h1);
    tx_ready = 3'b001;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("ch1_drain_data", 32'(tx_data[7:0]), 32'(8'h81 + i));
      tick();
    end
    tx_ready = 3'b000;
    checkOutput("ef_mode1_drained", 32'(EF1), 32'h0);

    // Full RX on channel 2 with a push and an INP in the same cycle.
    for (int i = 0; i < 4; i++)
      pushRx(1, 8'(8'hB0 + i));
    checkOutput("rxfull_ready", 32'(rx_ready), 32'h5);
    rx_valid[1] = 1'b1;
    rx_data[15:8] = 8'hEE;
    applyStimulus(3'd2, 1'b1, 8'h00);
    checkOutput("rxfull_pop", 32'(bus_in), 32'hB0);
    tick();
    rx_valid[1] = 1'b0;
    #1;
    checkOutput("rxfull_ready_after", 32'(rx_ready), 32'h7);
    for (int i = 1; i < 4; i++) begin
      checkOutput("rxfull_rest", 32'(bus_in), 32'(8'hB0 + i));
      tick();
    end
    #1;
    checkOutput("rxfull_count3", 32'(bus_in), 32'h00);
    tick();
    applyStimulus(3'd0, 1'b0, 8'h00);
    checkOutput("rxfull_unf", 32'(unf), 32'h2);
    clearErrors();

    // Pointer wrap: ten bytes through channel 3 with overlapping push/pop.
    pushRx(2, 8'h50);
    for (int i = 1; i < 10; i++) begin
      rx_valid[2] = 1'b1;
      rx_data[23:16] = 8'(8'h50 + i);
      applyStimulus(3'd3, 1'b1, 8'h00);
      checkOutput("wrap_data", 32'(bus_in), 32'(8'h50 + i - 1));
      tick();
    end
    rx_valid[2] = 1'b0;
    #1;
    checkOutput("wrap_last", 32'(bus_in), 32'h59);
    tick();
    applyStimulus(3'd0, 1'b0, 8'h00);
    checkOutput("wrap_unf", 32'(unf), 32'h0);
    checkOutput("wrap_empty_ef", 32'(EF), 32'h0);

    // Out-of-range channel and idle strobes.
    applyStimulus(3'd5, 1'b0, 8'hFF);
    tick();
    applyStimulus(3'd5, 1'b1, 8'h00);
    checkOutput("oor_bus_in", 32'(bus_in), 32'h00);
    tick();
    applyStimulus(3'd0, 1'b1, 8'h00);
    checkOutput("idle_inp_bus_in", 32'(bus_in), 32'h00);
    checkOutput("oor_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("oor_rx_ready", 32'(rx_ready), 32'h7);
    checkOutput("oor_flags", 32'({ovf, unf}), 32'h0);
    applyStimulus(3'd1, 1'b0, 8'h00);
    checkOutput("out_strobe_bus_in", 32'(bus_in), 32'h00);
    applyStimulus(3'd0, 1'b0, 8'h00);

    // Asynchronous reset in the middle of activity.
    pushRx(1, 8'hC1);
    applyStimulus(3'd1, 1'b0, 8'hD1);
    tick();
    applyStimulus(3'd2, 1'b1, 8'h00);
    #2;
    resetq = 1'b0;
    #1;
    checkOutput("midrst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("midrst_rx_ready", 32'(rx_ready), 32'h7);
    checkOutput("midrst_ef",       32'(EF),       32'h0);
    checkOutput("midrst_flags",    32'({ovf, unf}), 32'h0);
    checkOutput("midrst_bus_in",   32'(bus_in),   32'h00);
    applyStimulus(3'd0, 1'b0, 8'h00);
    tick();
    resetq = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
